// File: rtl/core_bus_arbiter.sv
// Single-master bus arbiter: D-over-I priority with a starvation guard and 1-cycle read return routing.
// Define CORE_ARB_PERF_EN to add the perf_conflicts / perf_forced counters.
module core_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ren,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_ren,
  input  logic            d_wen,
  input  logic [AW-1:0]   d_raddr,
  input  logic [AW-1:0]   d_waddr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_bytemask,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            b_ren,
  output logic            b_wen,
  output logic [AW-1:0]   b_raddr,
  output logic [AW-1:0]   b_waddr,
  output logic [DW-1:0]   b_wdata,
  output logic [DW/8-1:0] b_bytemask,
  input  logic [DW-1:0]   b_rdata
`ifdef CORE_ARB_PERF_EN
  ,
  output logic [31:0]     perf_conflicts,
  output logic [31:0]     perf_forced
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DATA} owner_t;

  // Counter is kept 1 bit wide when the guard is off so the type stays legal.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  owner_t        owner_q, owner_d;
  logic [CW-1:0] starve_cnt;
  logic          d_req, conflict, forced;

  assign d_req    = d_ren | d_wen;
  assign conflict = i_ren & d_req;
  assign forced   = (STARVE_LIMIT != 0) && conflict && (starve_cnt == LIMIT);

  assign d_gnt = ~rst & d_req & ~forced;
  assign i_gnt = ~rst & i_ren & (~d_req | forced);

  always_comb begin
    b_ren      = 1'b0;
    b_wen      = 1'b0;
    b_raddr    = '0;
    b_waddr    = '0;
    b_wdata    = '0;
    b_bytemask = '0;
    if (d_gnt) begin
      b_ren      = d_ren;
      b_wen      = d_wen;
      b_raddr    = d_raddr;
      b_waddr    = d_waddr;
      b_wdata    = d_wdata;
      b_bytemask = d_bytemask;
    end else if (i_gnt) begin
      b_ren   = 1'b1;
      b_raddr = i_addr;
    end
  end

  // Read-return owner: state register / next state / outputs.
  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt)              owner_d = OWN_IFETCH;
    else if (d_gnt & d_ren) owner_d = OWN_DATA;
  end

  // Gated by rst so a read issued just before reset never returns.
  always_comb begin
    i_rvalid = ~rst & (owner_q == OWN_IFETCH);
    d_rvalid = ~rst & (owner_q == OWN_DATA);
  end

  assign i_rdata = b_rdata;
  assign d_rdata = b_rdata;

  always_ff @(posedge clk) begin
    if (rst || !i_ren || i_gnt)            starve_cnt <= '0;
    else if (d_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
  end

`ifdef CORE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts <= '0;
      perf_forced    <= '0;
    end else begin
      if (conflict) perf_conflicts <= perf_conflicts + 32'd1;
      if (forced)   perf_forced    <= perf_forced + 32'd1;
    end
  end
`endif

endmodule
